// File: rtl/sdc_pkg.sv
// Shared definitions for the multi-block SD data receiver: FSM states, bus modes,
// CRC16 polynomial and errSticky bit positions.
package sdc_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWaitStart,
      StRxData,
      StRxCrc,
      StRxStop
   } sdc_state_e;

   localparam logic [1:0] BusMode1 = 2'd0;
   localparam logic [1:0] BusMode4 = 2'd1;
   localparam logic [1:0] BusMode8 = 2'd2;

   localparam logic [15:0] Crc16Poly = 16'h1021;

   localparam int unsigned ErrCrc     = 0;
   localparam int unsigned ErrFrame   = 1;
   localparam int unsigned ErrTimeout = 2;

   function automatic logic [7:0] lane_mask(input logic [1:0] mode);
      case (mode)
         BusMode4: return 8'h0F;
         BusMode8: return 8'hFF;
         default:  return 8'h01;
      endcase
   endfunction

   // Index of the final sample of a byte: 8, 2 or 1 samples per byte.
   function automatic logic [2:0] last_bit_idx(input logic [1:0] mode);
      case (mode)
         BusMode4: return 3'd1;
         BusMode8: return 3'd0;
         default:  return 3'd7;
      endcase
   endfunction

endpackage

// File: rtl/sdc_crc16_lane.sv
// Single-lane serial CRC16 (x^16+x^12+x^5+1) with clock enable and synchronous clear.
// Only present when SDC_RX_CRC_EN is defined.
`ifdef SDC_RX_CRC_EN
module sdc_crc16_lane
   import sdc_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        ce_i,
   input  logic        clr_i,
   input  logic        bit_i,
   output logic [15:0] crc_o
);

   logic [15:0] crc_q, crc_d;
   logic        fb;

   always_comb begin
      fb    = bit_i ^ crc_q[15];
      crc_d = crc_q;
      if (clr_i) begin
         crc_d = '0;
      end else if (ce_i) begin
         crc_d = {crc_q[14:0], 1'b0} ^ (fb ? Crc16Poly : 16'h0000);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) crc_q <= '0;
      else         crc_q <= crc_d;
   end

   assign crc_o = crc_q;

endmodule
`endif

// File: rtl/sdc_data_receiver_mb.sv
// Multi-block 1/4/8-bit SD data receiver packing payload into OUT_W-bit words.
// Per-lane CRC16 checking is built only when SDC_RX_CRC_EN is defined.
module sdc_data_receiver_mb
   import sdc_pkg::*;
#(
   parameter int unsigned BLKSIZE_W = 12,
   parameter int unsigned BLKCNT_W  = 16,
   parameter int unsigned OUT_W     = 32,
   parameter int unsigned TIMEOUT_W = 24
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ce,
   input  logic                 start,
   input  logic                 abort,
   input  logic [1:0]           busMode,
   input  logic [BLKSIZE_W-1:0] blkSize,
   input  logic [BLKCNT_W-1:0]  blkCnt,
   input  logic [TIMEOUT_W-1:0] timeoutVal,
   input  logic [7:0]           sdDat,
   output logic [OUT_W-1:0]     out_data,
   output logic [OUT_W/8-1:0]   out_keep,
   output logic                 out_valid,
   output logic                 out_last,
   output logic                 blkDone,
   output logic                 crcError,
   output logic [2:0]           errSticky,
   output logic                 busy,
   output logic                 done,
   output logic                 sdBusy
);

   localparam int unsigned NumLanes = OUT_W / 8;
   localparam logic [1:0]  LaneMax  = 2'(NumLanes - 1);

   sdc_state_e           state_q, state_d;
   logic [7:0]           dat_q, dat_d;
   logic [1:0]           mode_q, mode_d;
   logic [BLKSIZE_W-1:0] bsize_q, bsize_d, byte_cnt_q, byte_cnt_d;
   logic [BLKCNT_W-1:0]  bcnt_q, bcnt_d, blk_q, blk_d, blk_inc;
   logic [TIMEOUT_W-1:0] tval_q, tval_d, tmo_q, tmo_d, tmo_inc;
   logic [2:0]           bit_q, bit_d;
   logic [1:0]           lane_q, lane_d;
   logic [7:0]           shreg_q, shreg_d, byte_n;
   logic [OUT_W-1:0]     word_q, word_d, word_n;
   logic [3:0]           crc_cnt_q, crc_cnt_d;
   logic [OUT_W-1:0]     out_data_q, out_data_d;
   logic [OUT_W/8-1:0]   out_keep_q, out_keep_d;
   logic                 out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic                 blk_done_q, blk_done_d, crc_error_q, crc_error_d;
   logic                 done_q, done_d;
   logic [2:0]           err_q, err_d;
   logic                 byte_last, crc_bad;

   assign byte_last = (byte_cnt_q == bsize_q);
   assign blk_inc   = blk_q + 1'b1;
   assign tmo_inc   = tmo_q + 1'b1;

`ifdef SDC_RX_CRC_EN
   logic        crc_en, crc_clr;
   logic [15:0] crc_lane [8];
   logic [7:0]  lane_bad;

   assign crc_en  = ce && (state_q == StRxData || state_q == StRxCrc);
   assign crc_clr = ce && (state_q == StWaitStart);

   for (genvar g = 0; g < 8; g++) begin : g_crc
      sdc_crc16_lane u_crc (
         .clk_i  (clk),
         .rst_ni (rst_n),
         .ce_i   (crc_en),
         .clr_i  (crc_clr),
         .bit_i  (dat_q[g]),
         .crc_o  (crc_lane[g])
      );
      // Running the received CRC through the same register leaves zero on a match.
      assign lane_bad[g] = (crc_lane[g] != 16'h0000);
   end

   assign crc_bad = |(lane_bad & lane_mask(mode_q));
`else
   assign crc_bad = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      dat_d       = ce ? sdDat : dat_q;
      mode_d      = mode_q;
      bsize_d     = bsize_q;
      bcnt_d      = bcnt_q;
      tval_d      = tval_q;
      tmo_d       = tmo_q;
      blk_d       = blk_q;
      byte_cnt_d  = byte_cnt_q;
      bit_d       = bit_q;
      lane_d      = lane_q;
      shreg_d     = shreg_q;
      word_d      = word_q;
      crc_cnt_d   = crc_cnt_q;
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      blk_done_d  = 1'b0;
      crc_error_d = 1'b0;
      done_d      = 1'b0;
      err_d       = err_q;
      byte_n      = shreg_q;
      word_n      = word_q;

      if (abort) begin
         if (state_q != StIdle) begin
            state_d = StIdle;
            done_d  = 1'b1;
         end
      end else if (start && state_q == StIdle) begin
         mode_d  = busMode;
         bsize_d = blkSize;
         bcnt_d  = blkCnt;
         tval_d  = timeoutVal;
         err_d   = '0;
         tmo_d   = '0;
         blk_d   = '0;
         state_d = StWaitStart;
      end else if (ce) begin
         unique case (state_q)
            StWaitStart: begin
               byte_cnt_d = '0;
               bit_d      = '0;
               lane_d     = '0;
               word_d     = '0;
               crc_cnt_d  = '0;
               if (!dat_q[0]) begin
                  state_d = StRxData;
               end else if (tmo_inc >= tval_q) begin
                  err_d[ErrTimeout] = 1'b1;
                  state_d           = StIdle;
                  done_d            = 1'b1;
               end else begin
                  tmo_d = tmo_inc;
               end
            end
            StRxData: begin
               case (mode_q)
                  BusMode8: byte_n = dat_q;
                  BusMode4: byte_n = {shreg_q[3:0], dat_q[3:0]};
                  default:  byte_n = {shreg_q[6:0], dat_q[0]};
               endcase
               shreg_d = byte_n;
               if (bit_q == last_bit_idx(mode_q)) begin
                  bit_d                        = '0;
                  word_n[int'(lane_q)*8 +: 8]  = byte_n;
                  byte_cnt_d                   = byte_cnt_q + 1'b1;
                  if (byte_last || lane_q == LaneMax) begin
                     out_data_d  = word_n;
                     out_valid_d = 1'b1;
                     out_last_d  = byte_last;
                     for (int k = 0; k < NumLanes; k++) out_keep_d[k] = (k <= int'(lane_q));
                     word_d = '0;
                     lane_d = '0;
                  end else begin
                     word_d = word_n;
                     lane_d = lane_q + 1'b1;
                  end
                  if (byte_last) state_d = StRxCrc;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
            StRxCrc: begin
               crc_cnt_d = crc_cnt_q + 4'd1;
               if (crc_cnt_q == 4'd15) state_d = StRxStop;
            end
            StRxStop: begin
               blk_done_d  = 1'b1;
               crc_error_d = crc_bad;
               if (crc_bad) err_d[ErrCrc] = 1'b1;
               if ((dat_q & lane_mask(mode_q)) != lane_mask(mode_q)) begin
                  err_d[ErrFrame] = 1'b1;
                  state_d         = StIdle;
                  done_d          = 1'b1;
               end else if (bcnt_q == '0 || blk_inc != bcnt_q) begin
                  blk_d   = blk_inc;
                  tmo_d   = '0;
                  state_d = StWaitStart;
               end else begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         dat_q       <= 8'hFF;
         mode_q      <= '0;
         bsize_q     <= '0;
         bcnt_q      <= '0;
         tval_q      <= '0;
         tmo_q       <= '0;
         blk_q       <= '0;
         byte_cnt_q  <= '0;
         bit_q       <= '0;
         lane_q      <= '0;
         shreg_q     <= '0;
         word_q      <= '0;
         crc_cnt_q   <= '0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         blk_done_q  <= 1'b0;
         crc_error_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         dat_q       <= dat_d;
         mode_q      <= mode_d;
         bsize_q     <= bsize_d;
         bcnt_q      <= bcnt_d;
         tval_q      <= tval_d;
         tmo_q       <= tmo_d;
         blk_q       <= blk_d;
         byte_cnt_q  <= byte_cnt_d;
         bit_q       <= bit_d;
         lane_q      <= lane_d;
         shreg_q     <= shreg_d;
         word_q      <= word_d;
         crc_cnt_q   <= crc_cnt_d;
         out_data_q  <= out_data_d;
         out_keep_q  <= out_keep_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         blk_done_q  <= blk_done_d;
         crc_error_q <= crc_error_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_keep  = out_keep_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign blkDone   = blk_done_q;
   assign crcError  = crc_error_q;
   assign errSticky = err_q;
   assign busy      = (state_q != StIdle);
   assign done      = done_q;
   assign sdBusy    = ~dat_q[0];

endmodule

// File: tb/tb_sdc_data_receiver_mb.sv
// Randomized self-checking bench for sdc_data_receiver_mb (default parameters).
module tb_sdc_data_receiver_mb;

`ifdef SDC_RX_CRC_EN
   localparam bit CrcEn = 1'b1;
`else
   localparam bit CrcEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, ce, start, abort;
   logic [1:0]  busMode;
   logic [11:0] blkSize;
   logic [15:0] blkCnt;
   logic [23:0] timeoutVal;
   logic [7:0]  sdDat;
   logic [31:0] out_data;
   logic [3:0]  out_keep;
   logic        out_valid, out_last, blkDone, crcError, busy, done, sdBusy;
   logic [2:0]  errSticky;

   sdc_data_receiver_mb dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ce         (ce),
      .start      (start),
      .abort      (abort),
      .busMode    (busMode),
      .blkSize    (blkSize),
      .blkCnt     (blkCnt),
      .timeoutVal (timeoutVal),
      .sdDat      (sdDat),
      .out_data   (out_data),
      .out_keep   (out_keep),
      .out_valid  (out_valid),
      .out_last   (out_last),
      .blkDone    (blkDone),
      .crcError   (crcError),
      .errSticky  (errSticky),
      .busy       (busy),
      .done       (done),
      .sdBusy     (sdBusy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Observed traffic, written only by the monitor.
   logic [31:0] got_data [512];
   logic [3:0]  got_keep [512];
   logic        got_last [512];
   logic        got_crc  [64];
   int          n_words = 0, n_blk = 0, n_done = 0;

   always @(negedge clk) begin
      if (out_valid) begin
         if (n_words < 512) begin
            got_data[n_words] <= out_data;
            got_keep[n_words] <= out_keep;
            got_last[n_words] <= out_last;
         end
         n_words <= n_words + 1;
      end
      if (blkDone) begin
         if (n_blk < 64) got_crc[n_blk] <= crcError;
         n_blk <= n_blk + 1;
      end
      if (done) n_done <= n_done + 1;
   end

   // Reference model state, written only by the stimulus block.
   logic [31:0] exp_data [512];
   logic [3:0]  exp_keep [512];
   logic        exp_last [512];
   int          exp_n = 0;
   bit          lb [8][4096];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // CRC16 as remainder of message*x^16 divided by the generator.
   function automatic logic [15:0] crc_div(input int lane, input int n);
      logic [15:0] r;
      logic        top;
      r = 16'h0000;
      for (int i = 0; i < n + 16; i++) begin
         top = r[15];
         r   = {r[14:0], (i < n) ? lb[lane][i] : 1'b0};
         if (top) r = r ^ 16'h1021;
      end
      return r;
   endfunction

   task automatic send_ce(input logic [7:0] v);
      sdDat = v;
      ce    = 1'b1;
      @(negedge clk);
      ce = 1'b0;
      repeat ($urandom_range(2)) @(negedge clk);
   endtask

   function automatic logic [7:0] fill(input logic [7:0] v, input logic [7:0] m);
      logic [7:0] r;
      r = 8'($urandom);
      return (v & m) | (r & ~m);
   endfunction

   task automatic arm(input logic [1:0] m, input int bsz, input int bcnt, input int tv);
      send_ce(8'hFF);
      busMode    = m;
      blkSize    = bsz[11:0];
      blkCnt     = bcnt[15:0];
      timeoutVal = tv[23:0];
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
      busMode    = 2'($urandom);
      blkSize    = 12'($urandom);
      blkCnt     = 16'($urandom);
      timeoutVal = 24'($urandom);
   endtask

   task automatic flush();
      repeat (3) send_ce(8'hFF);
      repeat (3) @(negedge clk);
   endtask

   // One block on the wire: idle, start bit, payload, per-lane CRC, stop bit.
   task automatic send_block(input int w, input int nbytes, input int crc_lane,
                             input int stop_lane, input int abort_at, input bit rec);
      logic [7:0]  m, v, byt;
      logic [7:0]  pay [$];
      logic [15:0] crc [8];
      logic [31:0] d;
      int          nb, val, lb_n, dce;
      m    = (w == 8) ? 8'hFF : (w == 4) ? 8'h0F : 8'h01;
      lb_n = 0;
      dce  = 0;
      send_ce(fill(8'hFF, m));
      send_ce(fill(8'h00, m));
      for (int b = 0; b < nbytes; b++) begin
         byt = 8'($urandom);
         pay.push_back(byt);
         for (int g = 0; g < 8 / w; g++) begin
            val = (int'(byt) >> (8 - w * (g + 1))) & ((1 << w) - 1);
            v   = val[7:0];
            for (int j = 0; j < w; j++) lb[j][lb_n] = v[j];
            lb_n++;
            send_ce(fill(v, m));
            dce++;
            if (dce == abort_at) begin
               abort = 1'b1;
               start = 1'b1;
               @(negedge clk);
               abort = 1'b0;
               start = 1'b0;
               chk("abort_busy", busy, 0);
               chk("abort_done", done, 1);
               @(negedge clk);
               chk("abort_start_ignored", busy, 0);
            end
         end
      end
      for (int j = 0; j < w; j++) crc[j] = crc_div(j, lb_n);
      for (int k = 0; k < 16; k++) begin
         v = 8'h00;
         for (int j = 0; j < w; j++) v[j] = crc[j][15 - k];
         if (crc_lane >= 0 && k == 7) v[crc_lane] = ~v[crc_lane];
         send_ce(fill(v, m));
      end
      v = m;
      if (stop_lane >= 0) v[stop_lane] = 1'b0;
      send_ce(fill(v, m));
      if (rec) begin
         for (int i = 0; i < nbytes; i += 4) begin
            nb = (nbytes - i < 4) ? nbytes - i : 4;
            d  = '0;
            for (int k = 0; k < nb; k++) d[8 * k +: 8] = pay[i + k];
            exp_data[exp_n] = d;
            exp_keep[exp_n] = 4'((1 << nb) - 1);
            exp_last[exp_n] = (i + 4 >= nbytes);
            exp_n++;
         end
      end
   endtask

   task automatic cmp_words(input string tag, input int w0, input int e0);
      int n;
      chk({tag, "_nwords"}, n_words - w0, exp_n - e0);
      n = (n_words - w0 < exp_n - e0) ? n_words - w0 : exp_n - e0;
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_data%0d", tag, i), got_data[w0 + i], exp_data[e0 + i]);
         chk($sformatf("%s_keep%0d", tag, i), got_keep[w0 + i], exp_keep[e0 + i]);
         chk($sformatf("%s_last%0d", tag, i), got_last[w0 + i], exp_last[e0 + i]);
      end
   endtask

   int w0, e0, b0, d0, idle_at;

   initial begin
      rst_n = 1'b0; ce = 1'b0; start = 1'b0; abort = 1'b0;
      busMode = '0; blkSize = '0; blkCnt = '0; timeoutVal = '0; sdDat = 8'hFF;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_keep", out_keep, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_blkDone", blkDone, 0);
      chk("rst_crcError", crcError, 0);
      chk("rst_errSticky", errSticky, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sdBusy", sdBusy, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 4-bit, 512-byte single block
      w0 = n_words; e0 = exp_n; b0 = n_blk; d0 = n_done;
      arm(2'd1, 511, 1, 1000);
      send_block(4, 512, -1, -1, -1, 1'b1);
      flush();
      chk("t1_nwords128", n_words - w0, 128);
      cmp_words("t1", w0, e0);
      chk("t1_blkdone", n_blk - b0, 1);
      chk("t1_crc", got_crc[b0], 0);
      chk("t1_done", n_done - d0, 1);
      chk("t1_err", errSticky, 0);
      chk("t1_busy", busy, 0);

      // 1-bit, 6-byte blocks x2: keep F then 3
      w0 = n_words; e0 = exp_n; b0 = n_blk; d0 = n_done;
      arm(2'd0, 5, 2, 1000);
      send_block(1, 6, -1, -1, -1, 1'b1);
      send_block(1, 6, -1, -1, -1, 1'b1);
      flush();
      cmp_words("t2", w0, e0);
      chk("t2_keep1", got_keep[w0 + 1], 4'h3);
      chk("t2_blkdone", n_blk - b0, 2);
      chk("t2_done", n_done - d0, 1);

      // 8-bit, 3 blocks, CRC corrupted on DAT5 in block 2
      w0 = n_words; e0 = exp_n; b0 = n_blk; d0 = n_done;
      arm(2'd2, 9, 3, 1000);
      send_block(8, 10, -1, -1, -1, 1'b1);
      send_block(8, 10, 5, -1, -1, 1'b1);
      send_block(8, 10, -1, -1, -1, 1'b1);
      flush();
      cmp_words("t3", w0, e0);
      chk("t3_blkdone", n_blk - b0, 3);
      chk("t3_crc1", got_crc[b0], 0);
      chk("t3_crc2", got_crc[b0 + 1], CrcEn);
      chk("t3_crc3", got_crc[b0 + 2], 0);
      chk("t3_err", errSticky, {2'b00, CrcEn});
      chk("t3_done", n_done - d0, 1);

      // Start-bit timeout after 100 ce
      w0 = n_words; b0 = n_blk; d0 = n_done; idle_at = 0;
      arm(2'd0, 3, 1, 100);
      for (int i = 1; i <= 300; i++) begin
         send_ce(8'($urandom) | 8'h01);
         if (!busy) begin
            idle_at = i;
            break;
         end
      end
      repeat (2) @(negedge clk);
      chk("t4_timeout_ce", idle_at, 100);
      chk("t4_err", errSticky, 3'b100);
      chk("t4_done", n_done - d0, 1);
      chk("t4_nwords", n_words - w0, 0);

      // Stop bit low on DAT2 in block 1 of 3
      w0 = n_words; e0 = exp_n; b0 = n_blk; d0 = n_done;
      arm(2'd1, 3, 3, 1000);
      send_block(4, 4, -1, 2, -1, 1'b1);
      send_block(4, 4, -1, -1, -1, 1'b0);
      flush();
      cmp_words("t5", w0, e0);
      chk("t5_err", errSticky, 3'b010);
      chk("t5_blkdone", n_blk - b0, 1);
      chk("t5_done", n_done - d0, 1);
      chk("t5_busy", busy, 0);

      // Unbounded transfer, abort+start together mid-data, then a fresh transfer
      w0 = n_words; e0 = exp_n; b0 = n_blk; d0 = n_done;
      arm(2'd0, 15, 0, 1000);
      send_block(1, 16, -1, -1, 20, 1'b0);
      flush();
      chk("t6_nwords", n_words - w0, 0);
      chk("t6_blkdone", n_blk - b0, 0);
      chk("t6_done", n_done - d0, 1);
      chk("t6_busy", busy, 0);
      w0 = n_words; e0 = exp_n; b0 = n_blk; d0 = n_done;
      arm(2'd2, 3, 1, 1000);
      send_block(8, 4, -1, -1, -1, 1'b1);
      flush();
      cmp_words("t6b", w0, e0);
      chk("t6b_done", n_done - d0, 1);
      chk("t6b_err", errSticky, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
